rr_demux_stream: RTL and testbench

//  Streaming 1-to-N demultiplexer: the distribution side of the mux/mux4 select path.
//  - Takes one valid/ready input stream; deals accepted beats round-robin to NUM_OUT output channels.
//  - Each output channel has a one-entry output register (ch0 first, wrap).
//  - Sits between a shared producer and N parallel consumers.

---
 rtl/rr_demux_stream.sv | 106 ++++++++++
 tb/tb_rr_demux_stream.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_demux_stream.sv
// Purpose : 1-to-NUM_OUT stream demux; accepted beats are dealt round-robin into one-entry output slots.
// Latency : 1 clk from input accept to out_valid on the target channel.
// Backpr. : in_ready follows the target slot only (head-of-line). Other channels drain independently.
// Option  : DEMUX_STEER_EN replaces the round-robin pointer with a per-beat in_sel.
//           Out-of-range in_sel beats are accepted, discarded and flagged on drop_pulse.
module rr_demux_stream #(
  parameter  int W       = 8,
  parameter  int NUM_OUT = 4,
  localparam int SEL_W   = $clog2(NUM_OUT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
`ifdef DEMUX_STEER_EN
  input  logic [SEL_W-1:0]     in_sel,
  output logic                 drop_pulse,
`endif
  output logic [NUM_OUT*W-1:0] out_data,
  output logic [NUM_OUT-1:0]   out_valid,
  input  logic [NUM_OUT-1:0]   out_ready,
  output logic [SEL_W-1:0]     cur_sel
);

  // Highest legal channel index; used for the explicit wrap and the range check.
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_OUT - 1);

  logic [SEL_W-1:0]            tgt;
  logic                        tgt_ok;
  logic                        tgt_free;
  logic                        acc;
  logic [NUM_OUT-1:0]          load;
  logic [NUM_OUT-1:0]          vld_q;
  logic [NUM_OUT-1:0][W-1:0]   dat_q;

`ifdef DEMUX_STEER_EN
  logic drop_q;

  assign tgt    = in_sel;
  // When NUM_OUT is a power of two every encoding is legal and this folds to 1.
  assign tgt_ok = (in_sel <= LAST);

  // One-cycle flag for a beat that was accepted but had no channel to go to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= 1'b0;
    else        drop_q <= acc & ~tgt_ok;
  end

  assign drop_pulse = drop_q;
`else
  logic [SEL_W-1:0] ptr;

  assign tgt    = ptr;
  assign tgt_ok = 1'b1;

  // Round-robin pointer: steps only on accept, wraps at NUM_OUT-1 (not at 2^SEL_W).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (acc) ptr <= (ptr == LAST) ? '0 : ptr + SEL_W'(1);
  end
`endif

  // Target slot can take a beat when it is empty or is being drained this cycle.
  // The search is a compare loop so an out-of-range target never indexes past the slot array.
  always_comb begin
    tgt_free = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (tgt == SEL_W'(k)) tgt_free = ~vld_q[k] | out_ready[k];
    end
  end

  assign in_ready = tgt_ok ? tgt_free : 1'b1;
  assign acc      = in_valid & in_ready;

  // Exactly one slot is loaded per accepted in-range beat.
  always_comb begin
    load = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      load[k] = acc & tgt_ok & (tgt == SEL_W'(k));
    end
  end

  // Output slots: a load wins over a drain, so drain+load keeps valid high with no bubble.
  // Data is only written on load, so it holds while stalled and after draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (load[k]) begin
          vld_q[k] <= 1'b1;
          dat_q[k] <= in_data;
        end else if (out_ready[k]) begin
          vld_q[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = vld_q;
  assign out_data  = dat_q;
  assign cur_sel   = tgt;

endmodule

// File: tb/tb_rr_demux_stream.sv
module tb_rr_demux_stream;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  // 4-channel instance
  logic        v4;
  logic        rdy4;
  logic [31:0] od4;
  logic [3:0]  ov4;
  logic [3:0]  or4;
  logic [1:0]  cs4;
  // 3-channel instance
  logic        v3;
  logic        rdy3;
  logic [23:0] od3;
  logic [2:0]  ov3;
  logic [2:0]  or3;
  logic [1:0]  cs3;

  int n_checks;
  int n_fail;

`ifdef DEMUX_STEER_EN
  logic [1:0] sel4;
  logic [1:0] sel3;
  logic       dp4;
  logic       dp3;
`endif

  rr_demux_stream #(.W(8), .NUM_OUT(4)) u4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (v4),
    .in_ready  (rdy4),
`ifdef DEMUX_STEER_EN
    .in_sel    (sel4),
    .drop_pulse(dp4),
`endif
    .out_data  (od4),
    .out_valid (ov4),
    .out_ready (or4),
    .cur_sel   (cs4)
  );

  rr_demux_stream #(.W(8), .NUM_OUT(3)) u3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (v3),
    .in_ready  (rdy3),
`ifdef DEMUX_STEER_EN
    .in_sel    (sel3),
    .drop_pulse(dp3),
`endif
    .out_data  (od3),
    .out_valid (ov3),
    .out_ready (or3),
    .cur_sel   (cs3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; in_data = 8'h00;
    v4 = 1'b0; or4 = 4'h0; v3 = 1'b0; or3 = 3'h0;
`ifdef DEMUX_STEER_EN
    sel4 = 2'd0; sel3 = 2'd0;
`endif
    #1;
    n_checks++; if (ov4 !== 4'h0) begin n_fail++; $display("FAIL reset_out_valid got %h want 0", ov4); end
    n_checks++; if (od4 !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", od4); end
    n_checks++; if (cs4 !== 2'd0) begin n_fail++; $display("FAIL reset_cur_sel got %0d want 0", cs4); end
    n_checks++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", rdy4); end
    n_checks++; if (ov3 !== 3'h0) begin n_fail++; $display("FAIL reset_out_valid3 got %h want 0", ov3); end
    @(negedge clk); rst_n = 1'b1;
  endtask

`ifndef DEMUX_STEER_EN
  // Full rate, all consumers ready: A0..A4 land on ch0,1,2,3,0.
  task automatic test_back_to_back();
    logic [7:0] exp_d;
    or4 = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_d = 8'hA0 + 8'(i);
      v4 = 1'b1; in_data = exp_d;
      #1;
      n_checks++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready beat %0d got %b want 1", i, rdy4); end
      n_checks++; if (cs4 !== 2'(i % 4)) begin n_fail++; $display("FAIL b2b_cur_sel beat %0d got %0d want %0d", i, cs4, i % 4); end
      @(posedge clk); #1;
      n_checks++; if (ov4[i % 4] !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid beat %0d got %h", i, ov4); end
      n_checks++; if (od4[(i % 4) * 8 +: 8] !== exp_d) begin n_fail++; $display("FAIL b2b_out_data beat %0d got %h want %h", i, od4[(i % 4) * 8 +: 8], exp_d); end
    end
    n_checks++; if (ov4 !== 4'b0001) begin n_fail++; $display("FAIL b2b_valid_map got %b want 0001", ov4); end
    n_checks++; if (od4 !== 32'hA3A2A1A4) begin n_fail++; $display("FAIL b2b_data_map got %h want a3a2a1a4", od4); end
    @(negedge clk); v4 = 1'b0;
    n_checks++; if (cs4 !== 2'd1) begin n_fail++; $display("FAIL b2b_final_sel got %0d want 1", cs4); end
  endtask

  // ch1 full and stalled with ptr=1: input stalls, then drain+load in one cycle.
  task automatic test_backpressure();
    or4 = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); v4 = 1'b1; in_data = 8'hB0 + 8'(i);
      @(posedge clk);
    end
    @(negedge clk); v4 = 1'b1; in_data = 8'hB4;
    #1;
    n_checks++; if (rdy4 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", rdy4); end
    n_checks++; if (cs4 !== 2'd1) begin n_fail++; $display("FAIL bp_cur_sel got %0d want 1", cs4); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (od4[15:8] !== 8'hB0) begin n_fail++; $display("FAIL bp_data_stable got %h want b0", od4[15:8]); end
    n_checks++; if (ov4 !== 4'b0010) begin n_fail++; $display("FAIL bp_valid got %b want 0010", ov4); end
    n_checks++; if (cs4 !== 2'd1) begin n_fail++; $display("FAIL bp_sel_hold got %0d want 1", cs4); end
    @(negedge clk); or4 = 4'hF;
    #1;
    n_checks++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", rdy4); end
    @(posedge clk); #1;
    n_checks++; if (ov4[1] !== 1'b1) begin n_fail++; $display("FAIL bp_no_bubble got %b want 1", ov4[1]); end
    n_checks++; if (od4[15:8] !== 8'hB4) begin n_fail++; $display("FAIL bp_new_beat got %h want b4", od4[15:8]); end
    n_checks++; if (cs4 !== 2'd2) begin n_fail++; $display("FAIL bp_sel_adv got %0d want 2", cs4); end
    @(negedge clk); v4 = 1'b0;
  endtask

  // Non-power-of-two channel count wraps 2 -> 0.
  task automatic test_num_out3();
    or3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); v3 = 1'b1; in_data = 8'hC0 + 8'(i);
      #1;
      n_checks++; if (cs3 !== 2'(i % 3)) begin n_fail++; $display("FAIL n3_cur_sel beat %0d got %0d want %0d", i, cs3, i % 3); end
      @(posedge clk);
    end
    #1;
    n_checks++; if (ov3 !== 3'b001) begin n_fail++; $display("FAIL n3_valid got %b want 001", ov3); end
    n_checks++; if (od3[7:0] !== 8'hC3) begin n_fail++; $display("FAIL n3_wrap_data got %h want c3", od3[7:0]); end
    n_checks++; if (cs3 !== 2'd1) begin n_fail++; $display("FAIL n3_final_sel got %0d want 1", cs3); end
    @(negedge clk); v3 = 1'b0;
  endtask

  // Build out_valid=1011 then assert reset between clock edges.
  task automatic test_reset_midstream();
    or4 = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); v4 = 1'b1; in_data = 8'hD0 + 8'(i);
      @(posedge clk);
    end
    @(negedge clk); v4 = 1'b0; or4 = 4'b0100;
    @(posedge clk);
    @(negedge clk); or4 = 4'h0;
    n_checks++; if (ov4 !== 4'b1011) begin n_fail++; $display("FAIL mid_prefill got %b want 1011", ov4); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (ov4 !== 4'h0) begin n_fail++; $display("FAIL mid_async_valid got %b want 0000", ov4); end
    n_checks++; if (od4 !== 32'h0) begin n_fail++; $display("FAIL mid_async_data got %h want 0", od4); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (cs4 !== 2'd0) begin n_fail++; $display("FAIL mid_ptr got %0d want 0", cs4); end
    n_checks++; if (ov4 !== 4'h0) begin n_fail++; $display("FAIL mid_post_valid got %b want 0000", ov4); end
  endtask
`else
  // Steered destination and out-of-range discard on the 3-channel instance.
  task automatic test_steer();
    or3 = 3'b000;
    @(negedge clk); v3 = 1'b1; sel3 = 2'd2; in_data = 8'h5A;
    #1;
    n_checks++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL st_ready got %b want 1", rdy3); end
    n_checks++; if (cs3 !== 2'd2) begin n_fail++; $display("FAIL st_cur_sel got %0d want 2", cs3); end
    @(posedge clk); #1;
    n_checks++; if (ov3 !== 3'b100) begin n_fail++; $display("FAIL st_valid got %b want 100", ov3); end
    n_checks++; if (od3[23:16] !== 8'h5A) begin n_fail++; $display("FAIL st_data got %h want 5a", od3[23:16]); end
    n_checks++; if (dp3 !== 1'b0) begin n_fail++; $display("FAIL st_no_drop got %b want 0", dp3); end
    @(negedge clk); sel3 = 2'd3; in_data = 8'h77;
    #1;
    n_checks++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL st_oor_ready got %b want 1", rdy3); end
    @(posedge clk); #1;
    n_checks++; if (dp3 !== 1'b1) begin n_fail++; $display("FAIL st_drop got %b want 1", dp3); end
    n_checks++; if (ov3 !== 3'b100) begin n_fail++; $display("FAIL st_drop_valid got %b want 100", ov3); end
    n_checks++; if (od3 !== 24'h5A0000) begin n_fail++; $display("FAIL st_drop_data got %h want 5a0000", od3); end
    @(negedge clk); v3 = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (dp3 !== 1'b0) begin n_fail++; $display("FAIL st_drop_one_cycle got %b want 0", dp3); end
    @(negedge clk); v3 = 1'b1; sel3 = 2'd2;
    #1;
    n_checks++; if (rdy3 !== 1'b0) begin n_fail++; $display("FAIL st_full_stall got %b want 0", rdy3); end
    @(negedge clk); v3 = 1'b0;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
`ifndef DEMUX_STEER_EN
    test_back_to_back();
    test_backpressure();
    test_num_out3();
    test_reset_midstream();
`else
    test_steer();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
